// File: rtl/k12a_mem_arbiter_if.sv
// K12A memory port bundle: CPU side, DMA/debug side and memory macro side.
// slave = arbiter view, master = CPU/DMA/memory environment view.
interface k12a_mem_arbiter_if;
    logic        cpu_mem_enable;
    logic        cpu_mem_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_ack;

    logic        mem_enable;
    logic        mem_mode;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_enable, mem_mode, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_enable, mem_mode, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/k12a_mem_arbiter.sv
// Shares the K12A memory port between the CPU FSM and a DMA/debug requester.
// CPU owns the port by default; DMA gets idle cycles or a forced grant.
module k12a_mem_arbiter #(
    parameter int unsigned BURST_MAX    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    k12a_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_DMA     = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam logic [7:0] LP_STARVE = 8'(STARVE_LIMIT);
    localparam logic [7:0] LP_BLAST  = 8'(BURST_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic [7:0] r_burst_cnt;
    logic [7:0] w_burst_nxt;
    logic       w_dma_own;
    logic       w_starved;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_CPU;
            r_wait_cnt  <= 8'd0;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    assign w_starved = (r_wait_cnt >= LP_STARVE);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_burst_nxt = r_burst_cnt;
        unique case (r_state)
            S_CPU: begin
                if (!bus.dma_req) begin
                    w_wait_nxt = 8'd0;
                end else if (!bus.cpu_mem_enable || w_starved) begin
                    w_state_nxt = S_DMA;
                    w_wait_nxt  = 8'd0;
                    w_burst_nxt = 8'd0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_DMA: begin
                // Last ack of a burst hands the port back for one cycle.
                if (!bus.dma_req) begin
                    w_state_nxt = S_CPU;
                end else if (r_burst_cnt == LP_BLAST) begin
                    w_state_nxt = S_HOLDOFF;
                    w_burst_nxt = 8'd0;
                end else begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end
            end
            S_HOLDOFF: begin
                w_state_nxt = S_CPU;
                w_wait_nxt  = 8'd0;
            end
            default: begin
                w_state_nxt = S_CPU;
                w_wait_nxt  = 8'd0;
                w_burst_nxt = 8'd0;
            end
        endcase
    end

    // Reset forces CPU pass-through so an aborted DMA write never lands.
    assign w_dma_own = (r_state == S_DMA) && !reset;

    always_comb begin
        bus.mem_enable = bus.cpu_mem_enable;
        bus.mem_mode   = bus.cpu_mem_mode;
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_wdata  = bus.cpu_wdata;
        bus.cpu_rdata  = bus.mem_rdata;
        bus.dma_rdata  = bus.mem_rdata;
        bus.cpu_stall  = 1'b0;
        bus.dma_ack    = 1'b0;
        if (w_dma_own) begin
            bus.mem_enable = bus.dma_req;
            bus.mem_mode   = bus.dma_we;
            bus.mem_addr   = bus.dma_addr;
            bus.mem_wdata  = bus.dma_wdata;
            bus.cpu_stall  = 1'b1;
            bus.dma_ack    = bus.dma_req;
        end
    end
endmodule
